gate_checker: RTL and testbench

GATE_CHECKER -- requirements
Module: gate_checker

---
 rtl/gate_checker_pkg.sv | 25 ++
 rtl/gate_checker_ref.sv | 24 ++
 rtl/gate_checker.sv | 117 +++++++++++
 tb/tb_gate_checker.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_checker_pkg.sv
// Shared definitions for the gate checker.
//   state_t          : FSM states of gate_checker
//   NOT_B .. XNOR_B  : bit position of each gate result within res_in
//   NUM_VECS         : number of a/b input combinations applied per run
package gate_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int NOT_B  = 0;
  localparam int BUF_B  = 1;
  localparam int AND_B  = 2;
  localparam int OR_B   = 3;
  localparam int NAND_B = 4;
  localparam int NOR_B  = 5;
  localparam int XOR_B  = 6;
  localparam int XNOR_B = 7;

  localparam int NUM_VECS = 4;

endpackage

// File: rtl/gate_checker_ref.sv
// gate_ref_model: combinational golden value of the eight gate outputs.
//   i_a, i_b : gate inputs currently applied
//   o_exp    : expected res_in, bit order as gate_checker_pkg bit constants
module gate_ref_model
  import gate_checker_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  output logic [7:0] o_exp
);

  always_comb begin
    o_exp         = '0;
    o_exp[NOT_B]  = ~i_a;
    o_exp[BUF_B]  = i_a;
    o_exp[AND_B]  = i_a & i_b;
    o_exp[OR_B]   = i_a | i_b;
    o_exp[NAND_B] = ~(i_a & i_b);
    o_exp[NOR_B]  = ~(i_a | i_b);
    o_exp[XOR_B]  = i_a ^ i_b;
    o_exp[XNOR_B] = ~(i_a ^ i_b);
  end

endmodule

// File: rtl/gate_checker.sv
// gate_checker: drives all four a/b combinations into an external gate
// block, waits SETTLE_CYCLES per vector, samples the eight gate results and
// compares them against gate_ref_model.
//   clk_in       : clock, rising edge
//   rst_in       : synchronous active-high reset
//   start_in     : run request, honoured only in IDLE
//   a_out, b_out : stimulus to the gate block (0 outside a run)
//   res_in       : gate block results
//   busy_out     : run in progress (SETTLE/SAMPLE)
//   done_out     : one-cycle completion pulse
//   pass_out     : last run had no mismatch
//   err_cnt_out  : vectors with any mismatching bit (0..4)
//   fail_vec_out : sticky per-gate mismatch flags
module gate_checker
  import gate_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  output logic       a_out,
  output logic       b_out,
  input  logic [7:0] res_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       pass_out,
  output logic [2:0] err_cnt_out,
  output logic [7:0] fail_vec_out
);

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [3:0]  r_settle;
  logic        r_pass;
  logic [2:0]  r_err;
  logic [7:0]  r_fail;

  state_t      w_next;
  logic        w_active;
  logic        w_settle_last;
  logic        w_last_vec;
  logic [7:0]  w_exp;
  logic [7:0]  w_mis;

  assign w_active      = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign w_settle_last = (r_settle == 4'(SETTLE_CYCLES - 1));
  assign w_last_vec    = (r_idx == 2'(NUM_VECS - 1));

  // Vector index drives a/b directly; gated so the gate block sees 00
  // whenever no run is active.
  assign a_out = w_active & r_idx[1];
  assign b_out = w_active & r_idx[0];

  gate_ref_model u_ref (
    .i_a   (a_out),
    .i_b   (b_out),
    .o_exp (w_exp)
  );

  assign w_mis = res_in ^ w_exp;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start_in) w_next = ST_SETTLE;
      ST_SETTLE: if (w_settle_last) w_next = ST_SAMPLE;
      ST_SAMPLE: w_next = w_last_vec ? ST_DONE : ST_SETTLE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_settle <= '0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_fail   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            r_idx    <= '0;
            r_settle <= '0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_fail   <= '0;
          end
        end
        ST_SETTLE: begin
          // Counter wraps to 0 on exit so the next vector starts fresh.
          r_settle <= w_settle_last ? 4'd0 : r_settle + 4'd1;
        end
        ST_SAMPLE: begin
          r_fail <= r_fail | w_mis;
          if (|w_mis) r_err <= r_err + 3'd1;
          // pass must include the final vector's mismatches, so it is
          // formed from the same-cycle OR rather than r_fail.
          if (w_last_vec) r_pass <= ((r_fail | w_mis) == 8'd0);
          else            r_idx  <= r_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy_out     = w_active;
  assign done_out     = (r_state == ST_DONE);
  assign pass_out     = r_pass;
  assign err_cnt_out  = r_err;
  assign fail_vec_out = r_fail;

endmodule

// File: tb/tb_gate_checker.sv
module tb_gate_checker;

  typedef struct packed {
    logic       pass;
    logic [2:0] err;
    logic [7:0] fail;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start [2];
  logic a_w [2], b_w [2], busy_w [2], done_w [2], pass_w [2];
  logic [2:0] err_w [2];
  logic [7:0] fvec_w [2];

  // Fault configuration of the gate block: stuck-at-0, stuck-at-1, inverted.
  logic [7:0] s0, s1, inv;

  exp_t sbq [2][$];
  exp_t hold_exp [2];
  bit   hold_vld [2];
  int   dones [2];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  // Truth of each gate straight from its definition.
  function automatic logic [7:0] ideal(input logic a, input logic b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: r[i] = !a;
        1: r[i] = a;
        2: r[i] = a && b;
        3: r[i] = a || b;
        4: r[i] = !(a && b);
        5: r[i] = !(a || b);
        6: r[i] = a != b;
        default: r[i] = a == b;
      endcase
    end
    return r;
  endfunction

  function automatic logic [7:0] faulty(input logic [7:0] x);
    return ((x & ~s0) | s1) ^ inv;
  endfunction

  // Expected run outcome: walk the four vectors and tally mismatches.
  function automatic exp_t model();
    exp_t e;
    int   nerr = 0;
    logic [7:0] f = '0;
    for (int v = 0; v < 4; v++) begin
      logic [7:0] good, mis;
      good = ideal(v[1], v[0]);
      mis  = good ^ faulty(good);
      if (mis != 0) nerr++;
      f |= mis;
    end
    e.pass = (f == 0);
    e.err  = 3'(nerr);
    e.fail = f;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int S = (g == 0) ? 1 : 3;
    logic [7:0] res;
    int   bcnt = 0, age = 0;
    logic [2:0] key, prev_key;
    bit   prev_busy = 0, prev_done = 0, rst_q = 0;

    gate_checker #(.SETTLE_CYCLES(S)) u_dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .start_in     (start[g]),
      .a_out        (a_w[g]),
      .b_out        (b_w[g]),
      .res_in       (res),
      .busy_out     (busy_w[g]),
      .done_out     (done_w[g]),
      .pass_out     (pass_w[g]),
      .err_cnt_out  (err_w[g]),
      .fail_vec_out (fvec_w[g])
    );

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
      // Monitor
      if (rst_q) begin
        bcnt = 0; prev_busy = 0; prev_done = 0;
      end else begin
        if (busy_w[g]) begin
          chk("idle_before_rerun", g, prev_done, 0);
          if (bcnt == 0) begin
            chk("start_pass", g, pass_w[g], 0);
            chk("start_err", g, err_w[g], 0);
            chk("start_fail", g, fvec_w[g], 0);
          end
          chk("vec_ab", g, {a_w[g], b_w[g]}, (bcnt / (S + 1)) % 4);
          bcnt++;
        end else if (done_w[g]) begin
          chk("done_after_busy", g, prev_busy, 1);
          chk("busy_len", g, bcnt, 4 * (S + 1));
          chk("ab_done", g, {a_w[g], b_w[g]}, 0);
          if (sbq[g].size() == 0) chk("unexpected_done", g, 1, 0);
          else begin
            exp_t e;
            e = sbq[g].pop_front();
            chk("pass", g, pass_w[g], e.pass);
            chk("err_cnt", g, err_w[g], e.err);
            chk("fail_vec", g, fvec_w[g], e.fail);
            hold_exp[g] = e;
            hold_vld[g] = 1;
          end
          dones[g]++;
          bcnt = 0;
        end else begin
          chk("ab_idle", g, {a_w[g], b_w[g]}, 0);
          chk("busy_end_without_done", g, prev_busy, 0);
          if (hold_vld[g]) begin
            chk("hold_pass", g, pass_w[g], hold_exp[g].pass);
            chk("hold_err", g, err_w[g], hold_exp[g].err);
            chk("hold_fail", g, fvec_w[g], hold_exp[g].fail);
          end
        end
        prev_busy = busy_w[g];
        prev_done = done_w[g];
      end
      // Gate block: output is garbage for S cycles after its inputs (or the
      // run) change, then settles to the (possibly faulty) gate function.
      key = {busy_w[g], a_w[g], b_w[g]};
      if (key === prev_key) age++;
      else age = 0;
      prev_key = key;
      if (age < S) res = 8'($urandom);
      else         res = faulty(ideal(a_w[g], b_w[g]));
    end
  end

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1 rst = 0;
    for (int g = 0; g < 2; g++) begin
      sbq[g].delete();
      hold_exp[g] = '0;
      hold_vld[g] = 1;
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_a", g, a_w[g], 0);
      chk("rst_b", g, b_w[g], 0);
      chk("rst_busy", g, busy_w[g], 0);
      chk("rst_done", g, done_w[g], 0);
      chk("rst_pass", g, pass_w[g], 0);
      chk("rst_err", g, err_w[g], 0);
      chk("rst_fail", g, fvec_w[g], 0);
    end
  endtask

  task automatic wait_done(input int g, input int target);
    for (int k = 0; k < 300 && dones[g] < target; k++) @(negedge clk);
    chk("done_timeout", g, dones[g] >= target, 1);
  endtask

  task automatic run(input int g);
    int n;
    n = dones[g];
    sbq[g].push_back(model());
    @(posedge clk); #1 start[g] = 1;
    @(posedge clk); #1 start[g] = 0;
    @(negedge clk);
    chk("busy_rise", g, busy_w[g], 1);
    wait_done(g, n + 1);
  endtask

  // start held high across nruns back-to-back runs.
  task automatic run_held(input int g, input int nruns);
    int n;
    n = dones[g];
    for (int i = 0; i < nruns; i++) sbq[g].push_back(model());
    @(posedge clk); #1 start[g] = 1;
    wait_done(g, n + nruns);
    start[g] = 0;
    repeat (20) @(negedge clk);
    chk("held_run_count", g, dones[g], n + nruns);
  endtask

  initial begin
    start[0] = 0; start[1] = 0;
    s0 = 0; s1 = 0; inv = 0;
    do_reset();

    // Correct gate block
    run(0); run(1);
    // xor stuck at 0
    s0 = 8'h40; run(0); run(1);
    // every result inverted
    s0 = 0; inv = 8'hFF; run(0); run(1);

    // Random fault patterns
    for (int i = 0; i < 24; i++) begin
      s0  = 8'($urandom) & 8'($urandom);
      s1  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      inv = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin s0 = 0; s1 = 0; inv = 0; end
      run($urandom_range(0, 1));
    end

    // start held high
    s0 = 0; s1 = 8'h08; inv = 0;
    run_held(0, 1); run_held(1, 1);
    s1 = 0;
    run_held(0, 2); run_held(1, 2);

    // Reset in the SETTLE of vector 2
    begin
      int n;
      bit found = 0;
      n = dones[0];
      sbq[0].push_back(model());
      @(posedge clk); #1 start[0] = 1;
      @(posedge clk); #1 start[0] = 0;
      for (int k = 0; k < 100 && !found; k++) begin
        @(negedge clk);
        if (a_w[0] === 1'b1 && b_w[0] === 1'b0) found = 1;
      end
      chk("reach_vec2", 0, found, 1);
      do_reset();
      repeat (15) @(negedge clk);
      chk("no_done_after_abort", 0, dones[0], n);
      run(0);
    end

    repeat (5) @(negedge clk);
    chk("sbq_empty", 0, sbq[0].size(), 0);
    chk("sbq_empty", 1, sbq[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
